// File: rtl/regfile_onehot.sv
// rtl/regfile_onehot.sv - 32 x WIDTH register file with one-hot gated write, two registered reads and sequenced scrub.
// Optional write-first read bypass when RF_BYPASS_EN is defined.
module regfile_onehot #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic             clock,
  input  logic             ctrl_reset_n,
  input  logic             ctrl_writeEnable,
  input  logic [31:0]      ctrl_writeSel,
  input  logic [WIDTH-1:0] data_writeReg,
  input  logic [4:0]       ctrl_readRegA,
  input  logic [4:0]       ctrl_readRegB,
  output logic [WIDTH-1:0] data_readRegA,
  output logic [WIDTH-1:0] data_readRegB,
  input  logic             ctrl_clear,
  output logic             clear_busy,
  output logic             sel_error
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] mem [32];

  logic             sel_onehot;
  logic [4:0]       wr_idx;
  logic             wr_attempt;
  logic             wr_commit;
  logic             scrub_we;
  logic             sel_error_q, sel_error_d;
  logic [WIDTH-1:0] rd_a_d, rd_b_d;

  // A value is one-hot when it is non-zero and clearing its lowest set bit leaves nothing.
  always_comb begin
    sel_onehot = (ctrl_writeSel != 32'd0) &&
                 ((ctrl_writeSel & (ctrl_writeSel - 32'd1)) == 32'd0);
    wr_idx = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (ctrl_writeSel[i]) wr_idx = 5'(i);
    end
  end

  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    scrub_we   = 1'b0;
    wr_attempt = 1'b0;
    case (state_q)
      IDLE: begin
        // A scrub request wins over a same-cycle write.
        if (ctrl_clear) begin
          state_d = CLEAR;
          cnt_d   = 5'd1;
        end else begin
          wr_attempt = ctrl_writeEnable;
        end
      end
      CLEAR: begin
        scrub_we = 1'b1;
        if (cnt_q == 5'd31) begin
          state_d = IDLE;
          cnt_d   = 5'd0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 5'd0;
      end
    endcase
  end

  assign wr_commit   = wr_attempt && sel_onehot && (wr_idx != 5'd0);
  assign sel_error_d = wr_attempt ? !sel_onehot : sel_error_q;

  always_comb begin
    rd_a_d = (ctrl_readRegA == 5'd0) ? '0 : mem[ctrl_readRegA];
    rd_b_d = (ctrl_readRegB == 5'd0) ? '0 : mem[ctrl_readRegB];
`ifdef RF_BYPASS_EN
    if (wr_commit && (ctrl_readRegA == wr_idx)) rd_a_d = data_writeReg;
    if (wr_commit && (ctrl_readRegB == wr_idx)) rd_b_d = data_writeReg;
`endif
  end

  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      sel_error_q   <= 1'b0;
      data_readRegA <= '0;
      data_readRegB <= '0;
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else begin
      sel_error_q   <= sel_error_d;
      data_readRegA <= rd_a_d;
      data_readRegB <= rd_b_d;
      // Scrub and write never coincide: writes are only accepted in IDLE.
      if (scrub_we)  mem[cnt_q]  <= CLEAR_VALUE;
      if (wr_commit) mem[wr_idx] <= data_writeReg;
    end
  end

  assign clear_busy = (state_q == CLEAR);
  assign sel_error  = sel_error_q;

endmodule

// File: tb/tb_regfile_onehot.sv
// tb/tb_regfile_onehot.sv - directed self-checking bench for regfile_onehot.
module tb_regfile_onehot;

  logic        clock;
  logic        ctrl_reset_n;
  logic        ctrl_writeEnable;
  logic [31:0] ctrl_writeSel;
  logic [31:0] data_writeReg;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic [31:0] data_readRegA;
  logic [31:0] data_readRegB;
  logic        ctrl_clear;
  logic        clear_busy;
  logic        sel_error;

  int checks = 0;
  int errors = 0;
  int n;

  regfile_onehot #(.WIDTH(32), .CLEAR_VALUE(32'h0)) dut (
    .clock            (clock),
    .ctrl_reset_n     (ctrl_reset_n),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeSel    (ctrl_writeSel),
    .data_writeReg    (data_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_readRegA    (data_readRegA),
    .data_readRegB    (data_readRegB),
    .ctrl_clear       (ctrl_clear),
    .clear_busy       (clear_busy),
    .sel_error        (sel_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] sel, input logic [31:0] data);
    ctrl_writeEnable = 1'b1;
    ctrl_writeSel    = sel;
    data_writeReg    = data;
    tick();
    ctrl_writeEnable = 1'b0;
    ctrl_writeSel    = 32'h0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b);
    ctrl_readRegA = a;
    ctrl_readRegB = b;
    tick();
  endtask

  initial begin
    ctrl_reset_n     = 1'b0;
    ctrl_writeEnable = 1'b0;
    ctrl_writeSel    = 32'h0;
    data_writeReg    = 32'h0;
    ctrl_readRegA    = 5'd0;
    ctrl_readRegB    = 5'd0;
    ctrl_clear       = 1'b0;
    tick();
    tick();
    check("reset_rda", data_readRegA, 32'h0);
    check("reset_rdb", data_readRegB, 32'h0);
    check("reset_busy", {31'h0, clear_busy}, 32'h0);
    check("reset_selerr", {31'h0, sel_error}, 32'h0);
    ctrl_reset_n = 1'b1;

    // Reset clears a written entry
    wr(32'h1 << 5, 32'hDEADBEEF);
    rd(5'd5, 5'd0);
    check("pre_reset_e5", data_readRegA, 32'hDEADBEEF);
    ctrl_reset_n = 1'b0;
    tick();
    ctrl_reset_n = 1'b1;
    rd(5'd5, 5'd5);
    check("post_reset_e5", data_readRegA, 32'h0);
    check("post_reset_busy", {31'h0, clear_busy}, 32'h0);
    check("post_reset_selerr", {31'h0, sel_error}, 32'h0);

    // Write/read on both ports
    wr(32'h0000_0400, 32'h12345678);
    rd(5'd10, 5'd10);
    check("wr10_rda", data_readRegA, 32'h12345678);
    check("wr10_rdb", data_readRegB, 32'h12345678);
    wr(32'h1, 32'hFFFF_FFFF);
    check("wr0_selerr", {31'h0, sel_error}, 32'h0);
    rd(5'd0, 5'd0);
    check("rd0_a", data_readRegA, 32'h0);
    check("rd0_b", data_readRegB, 32'h0);

    // Illegal selects
    wr(32'h1 << 1, 32'h0000_0111);
    wr(32'h0000_0003, 32'h0000_0BAD);
    check("multi_selerr", {31'h0, sel_error}, 32'h1);
    rd(5'd1, 5'd0);
    check("multi_e1", data_readRegA, 32'h0000_0111);
    check("multi_e0", data_readRegB, 32'h0);
    check("selerr_hold", {31'h0, sel_error}, 32'h1);
    wr(32'h1 << 2, 32'h0000_0022);
    check("legal_clears_selerr", {31'h0, sel_error}, 32'h0);
    wr(32'h0, 32'h0000_0BAD);
    check("zero_selerr", {31'h0, sel_error}, 32'h1);
    wr(32'h1 << 2, 32'h0000_0022);

    // Scrub: fill 1..31, clear with a same-cycle write to entry 7
    for (int i = 1; i < 32; i++) wr(32'h1 << i, 32'(i * 32'h11));
    rd(5'd7, 5'd31);
    check("fill_e7", data_readRegA, 32'h77);
    check("fill_e31", data_readRegB, 32'h20F);
    ctrl_clear       = 1'b1;
    ctrl_writeEnable = 1'b1;
    ctrl_writeSel    = 32'h1 << 7;
    data_writeReg    = 32'hFFFF_FFFF;
    ctrl_readRegA    = 5'd7;
    ctrl_readRegB    = 5'd7;
    tick();
    ctrl_clear       = 1'b0;
    ctrl_writeEnable = 1'b0;
    ctrl_writeSel    = 32'h0;
    check("clr_e7_untouched", data_readRegA, 32'h77);
    n = 0;
    while (clear_busy && n < 40) begin
      n++;
      if (n == 6) begin
        ctrl_writeEnable = 1'b1;
        ctrl_writeSel    = 32'h1 << 3;
        data_writeReg    = 32'h0000_BEEF;
      end else begin
        ctrl_writeEnable = 1'b0;
        ctrl_writeSel    = 32'h0;
      end
      tick();
      if (n == 1) check("scrub_e7_mid", data_readRegA, 32'h77);
    end
    ctrl_writeEnable = 1'b0;
    ctrl_writeSel    = 32'h0;
    check("busy_cycles", 32'(n), 32'd31);
    for (int i = 0; i < 32; i += 2) begin
      rd(5'(i), 5'(i + 1));
      check($sformatf("scrub_e%0d", i), data_readRegA, 32'h0);
      check($sformatf("scrub_e%0d", i + 1), data_readRegB, 32'h0);
    end

    // Reset in the middle of a scrub
    wr(32'h1 << 20, 32'h0000_2020);
    wr(32'h1 << 9, 32'h0000_0999);
    ctrl_clear = 1'b1;
    tick();
    ctrl_clear = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("midscrub_busy", {31'h0, clear_busy}, 32'h1);
    ctrl_reset_n = 1'b0;
    tick();
    ctrl_reset_n = 1'b1;
    check("abort_busy", {31'h0, clear_busy}, 32'h0);
    rd(5'd20, 5'd9);
    check("abort_e20", data_readRegA, 32'h0);
    check("abort_e9", data_readRegB, 32'h0);
    wr(32'h1 << 12, 32'h00C0_FFEE);
    rd(5'd12, 5'd12);
    check("after_abort_wr", data_readRegA, 32'h00C0_FFEE);

    // Read/write collision
    wr(32'h1 << 4, 32'h0000_AAAA);
    ctrl_readRegA    = 5'd4;
    ctrl_writeEnable = 1'b1;
    ctrl_writeSel    = 32'h1 << 4;
    data_writeReg    = 32'h0000_5555;
    tick();
    ctrl_writeEnable = 1'b0;
    ctrl_writeSel    = 32'h0;
`ifdef RF_BYPASS_EN
    check("collide_same_edge", data_readRegA, 32'h0000_5555);
`else
    check("collide_same_edge", data_readRegA, 32'h0000_AAAA);
`endif
    tick();
    check("collide_next", data_readRegA, 32'h0000_5555);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
